ysyx_23060236_btb_updater: RTL and testbench
============================================

Name: ysyx_23060236_btb_updater

Overview:
- Writer side of the BTB: sits at the end of EXU and consumes resolved control-flow results (PC, predicted next PC, actual next PC).
- Detects next-PC mispredictions and raises a registered redirect to IFU.
- Queues BTB correction writes in a small coalescing FIFO and drains them onto the BTB write port under a ready handshake.
- Maintains branch and mispredict performance counters.

Parameters:
- ADDR_LEN, 32, PC/address width.
- QDEPTH, 2, update FIFO depth in entries (power of two, >=2).
- FLUSH_CYCLES, 1, cycles in_ready is held low after a redirect pulse, for wrong-path squash.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a resolved instruction result is present.
- in_ready  output  1  updater can accept a result.
- in_pc  input  ADDR_LEN  PC of the resolved instruction.
- in_pred_npc  input  ADDR_LEN  next PC that fetch used (the BTB read result).
- in_actual_npc  input  ADDR_LEN  architecturally correct next PC.
- in_is_branch  input  1  instruction is a branch or jump (perf only).
- redirect_valid  output  1  one-cycle pulse: refetch from redirect_pc.
- redirect_pc  output  ADDR_LEN  refetch target.
- btb_wvalid  output  1  BTB write request (head of FIFO).
- btb_wready  input  1  BTB accepts the write this cycle.
- btb_awaddr  output  ADDR_LEN  write PC (tag/index source).
- btb_wdata  output  ADDR_LEN  write target.
- perf_branch_cnt  output  32  accepted branches/jumps.
- perf_mispred_cnt  output  32  accepted mispredictions.

Behaviour:
- Accept: a result is accepted when in_valid & in_ready.
- Mispredict: an accepted result with in_actual_npc != in_pred_npc. The comparison is full-width, unsigned equality.
- Every mispredict enqueues {in_pc, in_actual_npc}, including not-taken and non-branch cases. Writing pc+4 overwrites a stale or aliased entry; the BTB has no invalidate.
- Redirect: redirect_valid=1 and redirect_pc=in_actual_npc in the cycle after a mispredict accept, for exactly one cycle.
- States:
  - RUN: in_ready = !full.
  - REDIR: the redirect pulse cycle; in_ready=0.
  - FLUSH: counts FLUSH_CYCLES cycles with in_ready=0, then returns to RUN.
  - Transitions: RUN -> REDIR on mispredict accept. REDIR -> FLUSH (or -> RUN if FLUSH_CYCLES=0).
- Correct predictions leave the state in RUN; no enqueue, no redirect.
- FIFO write port:
  - btb_wvalid = !empty; btb_awaddr and btb_wdata come from the head entry and are stable while btb_wvalid & !btb_wready.
  - Pop on btb_wvalid & btb_wready.
  - An enqueue at accept cycle N is visible on btb_wvalid at N+1 at the earliest.
- Coalescing:
  - If the enqueue PC equals the tail entry PC, overwrite the tail data instead of allocating.
  - Exception: if the tail is the head and it is being popped this cycle, allocate a new entry instead. No update may be lost.
- Full / empty / simultaneous events:
  - in_ready=0 when full, even if a pop occurs the same cycle.
  - A simultaneous push and pop when not full keeps the count unchanged.
  - When empty, btb_wvalid=0 and btb_wready is ignored.
  - FIFO pointers wrap modulo QDEPTH.
- Counters:
  - perf_branch_cnt increments on accept with in_is_branch.
  - perf_mispred_cnt increments on mispredict accept.
  - Both are 32-bit and wrap at 2^32.
- Reset values: state=RUN, FIFO empty, in_ready=1, redirect_valid=0, redirect_pc=0, btb_wvalid=0, btb_awaddr=0, btb_wdata=0, both counters 0.
- Reset mid-operation: reset asserted during REDIR, FLUSH, or a pending write discards the FIFO contents and any pending redirect. No write or redirect is emitted after reset.

Test Plan:
- Correct prediction: pc=0x80000000, pred=actual=0x80000004, is_branch=1, btb_wready=1 -> no redirect, btb_wvalid stays 0, perf_branch_cnt=1, perf_mispred_cnt=0.
- Taken mispredict: pc=0x80000010, pred=0x80000014, actual=0x80000100 -> next cycle redirect_valid=1 with redirect_pc=0x80000100; in_ready low for 1+FLUSH_CYCLES cycles; btb_wvalid with awaddr=0x80000010, wdata=0x80000100; perf_mispred_cnt=1.
- Backpressure/full: btb_wready=0, two mispredicts at different PCs (0x100, 0x200) -> FIFO full, in_ready=0 in RUN, head holds 0x100 stable. Raising btb_wready drains 0x100 then 0x200 in order.
- Coalescing: btb_wready=0, two mispredicts at pc=0x300 with actual 0x400 then 0x500 -> a single entry, wdata=0x500, in_ready stays 1. Repeating with btb_wready=1 during the second enqueue -> two writes, 0x400 then 0x500.
- Non-branch alias: is_branch=0, pc=0x40, pred=0x80, actual=0x44 -> redirect to 0x44, BTB write {0x40,0x44}, perf_branch_cnt unchanged.
- Reset mid-operation: assert reset in the REDIR cycle with one queued entry -> next cycle redirect_valid=0, btb_wvalid=0, counters 0, in_ready=1.

Source files
------------

// File: rtl/ysyx_23060236_btb_updater.sv
// ysyx_23060236_btb_updater
//   Writer side of the BTB, placed at the end of EXU. It compares the next PC
//   that fetch used against the resolved next PC. On a mismatch it:
//     - raises a registered one-cycle redirect to IFU,
//     - squashes wrong-path results for FLUSH_CYCLES cycles,
//     - queues a {pc, target} correction in a small coalescing FIFO.
//   The FIFO drains onto the BTB write port under a valid/ready handshake.
//   Branch and mispredict performance counters are also kept here.
//
// Ports
//   clock, reset        : clock and synchronous active-high reset
//   in_valid / in_ready : handshake for resolved results
//   in_pc               : PC of the resolved instruction
//   in_pred_npc         : next PC that fetch used
//   in_actual_npc       : architecturally correct next PC
//   in_is_branch        : branch/jump flag, used only by the perf counter
//   redirect_valid/_pc  : one-cycle refetch request and its target
//   btb_wvalid/_wready  : BTB write handshake, driven from the FIFO head
//   btb_awaddr/_wdata   : write PC (tag/index source) and write target
//   perf_branch_cnt     : number of accepted branches/jumps
//   perf_mispred_cnt    : number of accepted mispredictions
module ysyx_23060236_btb_updater #(
    parameter int unsigned ADDR_LEN     = 32,
    parameter int unsigned QDEPTH       = 2,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_LEN-1:0] in_pc,
    input  logic [ADDR_LEN-1:0] in_pred_npc,
    input  logic [ADDR_LEN-1:0] in_actual_npc,
    input  logic                in_is_branch,
    output logic                redirect_valid,
    output logic [ADDR_LEN-1:0] redirect_pc,
    output logic                btb_wvalid,
    input  logic                btb_wready,
    output logic [ADDR_LEN-1:0] btb_awaddr,
    output logic [ADDR_LEN-1:0] btb_wdata,
    output logic [31:0]         perf_branch_cnt,
    output logic [31:0]         perf_mispred_cnt
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam logic [31:0] FLUSH_LAST = (FLUSH_CYCLES > 0) ? 32'(FLUSH_CYCLES - 1) : 32'd0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_REDIR,
        ST_FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         flush_cnt_q, flush_cnt_d;
    logic [ADDR_LEN-1:0] redir_pc_q, redir_pc_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [ADDR_LEN-1:0] mem_pc_q  [QDEPTH];
    logic [ADDR_LEN-1:0] mem_pc_d  [QDEPTH];
    logic [ADDR_LEN-1:0] mem_tgt_q [QDEPTH];
    logic [ADDR_LEN-1:0] mem_tgt_d [QDEPTH];
    logic [31:0]         branch_cnt_q, branch_cnt_d;
    logic [31:0]         mispred_cnt_q, mispred_cnt_d;

    logic          full, empty;
    logic          accept, mispred, pop;
    logic          coalesce, alloc;
    logic [PW-1:0] tail_ptr;

    always_comb begin
        full     = (count_q == CW'(QDEPTH));
        empty    = (count_q == '0);
        in_ready = (state_q == ST_RUN) && !full;
        accept   = in_valid && in_ready;
        mispred  = accept && (in_actual_npc != in_pred_npc);
        pop      = !empty && btb_wready;
        tail_ptr = wr_ptr_q - PW'(1);
        // Coalescing into the tail is unsafe when that tail is the head being
        // written out this cycle: the new target would be lost, so allocate.
        coalesce = mispred && !empty && (mem_pc_q[tail_ptr] == in_pc)
                   && !(pop && (count_q == CW'(1)));
        alloc    = mispred && !coalesce;
    end

    always_comb begin
        mem_pc_d  = mem_pc_q;
        mem_tgt_d = mem_tgt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (coalesce) begin
            mem_tgt_d[tail_ptr] = in_actual_npc;
        end
        if (alloc) begin
            mem_pc_d[wr_ptr_q]  = in_pc;
            mem_tgt_d[wr_ptr_q] = in_actual_npc;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({alloc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        redir_pc_d  = redir_pc_q;

        case (state_q)
            ST_RUN: begin
                if (mispred) begin
                    state_d    = ST_REDIR;
                    redir_pc_d = in_actual_npc;
                end
            end
            ST_REDIR: begin
                flush_cnt_d = '0;
                state_d     = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + 32'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q + {31'd0, accept && in_is_branch};
        mispred_cnt_d = mispred_cnt_q + {31'd0, mispred};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            redir_pc_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redir_pc_q    <= redir_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count_q and the
    // outputs are gated while the FIFO is empty.
    always_ff @(posedge clock) begin
        mem_pc_q  <= mem_pc_d;
        mem_tgt_q <= mem_tgt_d;
    end

    assign redirect_valid   = (state_q == ST_REDIR);
    assign redirect_pc      = redir_pc_q;
    assign btb_wvalid       = !empty;
    assign btb_awaddr       = empty ? '0 : mem_pc_q[rd_ptr_q];
    assign btb_wdata        = empty ? '0 : mem_tgt_q[rd_ptr_q];
    assign perf_branch_cnt  = branch_cnt_q;
    assign perf_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_ysyx_23060236_btb_updater.sv
// Directed testbench for ysyx_23060236_btb_updater with the default
// parameters (ADDR_LEN=32, QDEPTH=2, FLUSH_CYCLES=1).
module tb_ysyx_23060236_btb_updater;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_pred_npc;
    logic [31:0] in_actual_npc;
    logic        in_is_branch;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        btb_wvalid;
    logic        btb_wready;
    logic [31:0] btb_awaddr;
    logic [31:0] btb_wdata;
    logic [31:0] perf_branch_cnt;
    logic [31:0] perf_mispred_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    ysyx_23060236_btb_updater #(
        .ADDR_LEN    (32),
        .QDEPTH      (2),
        .FLUSH_CYCLES(1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_pred_npc     (in_pred_npc),
        .in_actual_npc   (in_actual_npc),
        .in_is_branch    (in_is_branch),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .btb_wvalid      (btb_wvalid),
        .btb_wready      (btb_wready),
        .btb_awaddr      (btb_awaddr),
        .btb_wdata       (btb_wdata),
        .perf_branch_cnt (perf_branch_cnt),
        .perf_mispred_cnt(perf_mispred_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] pred,
                         input logic [31:0] act, input logic br);
        in_valid      = v;
        in_pc         = pc;
        in_pred_npc   = pred;
        in_actual_npc = act;
        in_is_branch  = br;
    endtask

    initial begin
        reset      = 1'b1;
        btb_wready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_redir_v", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'h0);
        chk("rst_wvalid", {31'd0, btb_wvalid}, 32'd0);
        chk("rst_awaddr", btb_awaddr, 32'h0);
        chk("rst_wdata", btb_wdata, 32'h0);
        chk("rst_br_cnt", perf_branch_cnt, 32'd0);
        chk("rst_mp_cnt", perf_mispred_cnt, 32'd0);

        // Correct prediction
        drive(1'b1, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("ok_redir_v", {31'd0, redirect_valid}, 32'd0);
        chk("ok_wvalid", {31'd0, btb_wvalid}, 32'd0);
        chk("ok_br_cnt", perf_branch_cnt, 32'd1);
        chk("ok_mp_cnt", perf_mispred_cnt, 32'd0);
        chk("ok_in_ready", {31'd0, in_ready}, 32'd1);

        // Taken mispredict; a wrong-path result stays presented during squash
        btb_wready = 1'b0;
        drive(1'b1, 32'h8000_0010, 32'h8000_0014, 32'h8000_0100, 1'b1);
        tick();
        chk("tk_redir_v", {31'd0, redirect_valid}, 32'd1);
        chk("tk_redir_pc", redirect_pc, 32'h8000_0100);
        chk("tk_ready_redir", {31'd0, in_ready}, 32'd0);
        chk("tk_wvalid", {31'd0, btb_wvalid}, 32'd1);
        chk("tk_awaddr", btb_awaddr, 32'h8000_0010);
        chk("tk_wdata", btb_wdata, 32'h8000_0100);
        chk("tk_mp_cnt", perf_mispred_cnt, 32'd1);
        chk("tk_br_cnt", perf_branch_cnt, 32'd2);
        tick();
        chk("tk_redir_v_off", {31'd0, redirect_valid}, 32'd0);
        chk("tk_ready_flush", {31'd0, in_ready}, 32'd0);
        tick();
        chk("tk_ready_run", {31'd0, in_ready}, 32'd1);
        chk("tk_squash_mp", perf_mispred_cnt, 32'd1);
        chk("tk_squash_br", perf_branch_cnt, 32'd2);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("tk_hold_awaddr", btb_awaddr, 32'h8000_0010);
        btb_wready = 1'b1;
        tick();
        chk("tk_drained", {31'd0, btb_wvalid}, 32'd0);

        // Backpressure / full
        btb_wready = 1'b0;
        drive(1'b1, 32'h100, 32'h104, 32'h500, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'h200, 32'h204, 32'h600, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_head_awaddr", btb_awaddr, 32'h100);
        chk("bp_head_wdata", btb_wdata, 32'h500);
        tick();
        chk("bp_stable_awaddr", btb_awaddr, 32'h100);
        btb_wready = 1'b1;
        chk("bp_full_pop_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_2nd_awaddr", btb_awaddr, 32'h200);
        chk("bp_2nd_wdata", btb_wdata, 32'h600);
        chk("bp_ready_after", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, btb_wvalid}, 32'd0);
        chk("bp_br_cnt", perf_branch_cnt, 32'd4);
        chk("bp_mp_cnt", perf_mispred_cnt, 32'd3);

        // Coalescing with the write port stalled
        btb_wready = 1'b0;
        drive(1'b1, 32'h300, 32'h304, 32'h400, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        drive(1'b1, 32'h300, 32'h304, 32'h500, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("co_awaddr", btb_awaddr, 32'h300);
        chk("co_wdata", btb_wdata, 32'h500);
        tick();
        tick();
        chk("co_ready", {31'd0, in_ready}, 32'd1);
        btb_wready = 1'b1;
        tick();
        chk("co_single", {31'd0, btb_wvalid}, 32'd0);

        // Same PC again, but the head is popped during the second enqueue
        btb_wready = 1'b0;
        drive(1'b1, 32'h300, 32'h304, 32'h400, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        btb_wready = 1'b1;
        drive(1'b1, 32'h300, 32'h304, 32'h500, 1'b0);
        chk("cp_first_wdata", btb_wdata, 32'h400);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("cp_second_wvalid", {31'd0, btb_wvalid}, 32'd1);
        chk("cp_second_wdata", btb_wdata, 32'h500);
        tick();
        chk("cp_empty", {31'd0, btb_wvalid}, 32'd0);
        chk("cp_mp_cnt", perf_mispred_cnt, 32'd7);
        tick();

        // Non-branch alias
        btb_wready = 1'b0;
        drive(1'b1, 32'h40, 32'h80, 32'h44, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("nb_redir_v", {31'd0, redirect_valid}, 32'd1);
        chk("nb_redir_pc", redirect_pc, 32'h44);
        chk("nb_awaddr", btb_awaddr, 32'h40);
        chk("nb_wdata", btb_wdata, 32'h44);
        chk("nb_br_cnt", perf_branch_cnt, 32'd4);
        chk("nb_mp_cnt", perf_mispred_cnt, 32'd8);

        // Reset in the REDIR cycle with one queued entry
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_redir_v", {31'd0, redirect_valid}, 32'd0);
        chk("mr_wvalid", {31'd0, btb_wvalid}, 32'd0);
        chk("mr_br_cnt", perf_branch_cnt, 32'd0);
        chk("mr_mp_cnt", perf_mispred_cnt, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("mr_redir_v2", {31'd0, redirect_valid}, 32'd0);
        chk("mr_wvalid2", {31'd0, btb_wvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
